// File: rtl/piece_fall_engine.sv
// Active-tetromino controller: spawns a piece, drops it on gravity ticks or hard drop,
// and locks it when the next row down collides with the floor or the locked board.
module piece_fall_engine #(
    parameter int ROWS      = 20,
    parameter int COLS      = 10,
    parameter int SPAWN_COL = 4,
    parameter int YW        = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spawn,
    input  logic [2:0]           piece_type,
    input  logic                 tick,
    input  logic                 hard_drop,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] piece_mask,
    output logic [YW-1:0]        block_y,
    output logic                 busy,
    output logic                 landed,
    output logic                 spawn_fail
);
    localparam int CELLS = ROWS * COLS;
    localparam int YW1   = YW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPAWN = 2'd1;
    localparam logic [1:0] ST_FALL  = 2'd2;
    localparam logic [1:0] ST_LAND  = 2'd3;

    localparam logic [2:0] TYPE_INVALID = 3'd7;

    logic [1:0]    state_reg, state_next;
    logic [YW-1:0] y_reg, y_next;
    logic [2:0]    type_reg, type_next;
    logic          drop_reg, drop_next;

    // One shape row as a 4-bit pattern; bit j is column SPAWN_COL-1+j.
    function automatic logic [3:0] shape_row(input logic [2:0] t, input logic [1:0] dr);
        logic [3:0] p;
        p = 4'b0000;
        case (t)
            3'd0: p = 4'b0010;
            3'd1: p = (dr <= 2'd1) ? 4'b0110 : 4'b0000;
            3'd2: p = (dr <= 2'd1) ? 4'b0010 : ((dr == 2'd2) ? 4'b0110 : 4'b0000);
            3'd3: p = (dr <= 2'd1) ? 4'b0100 : ((dr == 2'd2) ? 4'b0110 : 4'b0000);
            3'd4: p = (dr == 2'd0) ? 4'b1100 : ((dr == 2'd1) ? 4'b0110 : 4'b0000);
            3'd5: p = (dr == 2'd0) ? 4'b0110 : ((dr == 2'd1) ? 4'b1100 : 4'b0000);
            3'd6: p = (dr == 2'd0) ? 4'b0010 : ((dr == 2'd1) ? 4'b0111 : 4'b0000);
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] shape_height(input logic [2:0] t);
        logic [2:0] h;
        case (t)
            3'd0:                   h = 3'd4;
            3'd2, 3'd3:             h = 3'd3;
            3'd1, 3'd4, 3'd5, 3'd6: h = 3'd2;
            default:                h = 3'd0;
        endcase
        return h;
    endfunction

    logic [YW:0]      y_cur, y_dn;
    logic [CELLS-1:0] cur_mask, dn_mask;
    logic             cur_in_floor, dn_in_floor;
    logic             fits_cur, fits_dn;

    assign y_cur = {1'b0, y_reg};
    assign y_dn  = y_cur + YW1'(1);

    // Footprints at the current row and one row lower, built row by row.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [YW:0] rel_cur, rel_dn;
            logic [3:0]  pat_cur, pat_dn;

            assign rel_cur = YW1'(gi) - y_cur;
            assign rel_dn  = YW1'(gi) - y_dn;

            assign pat_cur = ((YW1'(gi) >= y_cur) && (rel_cur < YW1'(4)))
                           ? shape_row(type_reg, rel_cur[1:0]) : 4'b0000;
            assign pat_dn  = ((YW1'(gi) >= y_dn) && (rel_dn < YW1'(4)))
                           ? shape_row(type_reg, rel_dn[1:0]) : 4'b0000;

            assign cur_mask[gi*COLS +: COLS] = COLS'(pat_cur) << (SPAWN_COL - 1);
            assign dn_mask[gi*COLS +: COLS]  = COLS'(pat_dn) << (SPAWN_COL - 1);
        end
    endgenerate

    assign cur_in_floor = (y_cur + YW1'(shape_height(type_reg))) <= YW1'(ROWS);
    assign dn_in_floor  = (y_dn + YW1'(shape_height(type_reg))) <= YW1'(ROWS);

    assign fits_cur = cur_in_floor && ((cur_mask & board_in) == '0);
    assign fits_dn  = dn_in_floor && ((dn_mask & board_in) == '0);

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        type_next  = type_reg;
        drop_next  = drop_reg;
        case (state_reg)
            ST_IDLE: begin
                if (spawn && (piece_type != TYPE_INVALID)) begin
                    type_next  = piece_type;
                    y_next     = '0;
                    drop_next  = 1'b0;
                    state_next = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                state_next = fits_cur ? ST_FALL : ST_IDLE;
            end
            ST_FALL: begin
                if (hard_drop) begin
                    drop_next = 1'b1;
                end
                // tick and hard_drop together still make a single step
                if (drop_reg || hard_drop || tick) begin
                    if (fits_dn) begin
                        y_next = y_reg + YW'(1);
                    end else begin
                        state_next = ST_LAND;
                    end
                end
            end
            ST_LAND: begin
                state_next = ST_IDLE;
                drop_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            y_reg     <= '0;
            type_reg  <= '0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            type_reg  <= type_next;
            drop_reg  <= drop_next;
        end
    end

    assign piece_mask = ((state_reg == ST_FALL) || (state_reg == ST_LAND)) ? cur_mask : '0;
    assign block_y    = y_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign landed     = (state_reg == ST_LAND);
    assign spawn_fail = (state_reg == ST_SPAWN) && !fits_cur;

endmodule

// File: tb/tb_piece_fall_engine.sv
// Self-checking bench for piece_fall_engine: directed scenarios plus randomized play
// compared against a cell-list model of the falling piece.
module tb_piece_fall_engine;
    localparam int ROWS      = 20;
    localparam int COLS      = 10;
    localparam int SPAWN_COL = 4;
    localparam int YW        = 5;
    localparam int N         = ROWS * COLS;

    localparam int M_IDLE  = 0;
    localparam int M_SPAWN = 1;
    localparam int M_FALL  = 2;
    localparam int M_LAND  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         spawn = 1'b0;
    logic [2:0]   piece_type = 3'd0;
    logic         tick = 1'b0;
    logic         hard_drop = 1'b0;
    logic [N-1:0] board = '0;
    logic [N-1:0] piece_mask;
    logic [YW-1:0] block_y;
    logic         busy;
    logic         landed;
    logic         spawn_fail;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode = M_IDLE;
    int m_y    = 0;
    int m_type = 0;
    bit m_hd   = 1'b0;

    int dr_tab [7][4] = '{'{0,1,2,3}, '{0,0,1,1}, '{0,1,2,2}, '{0,1,2,2},
                          '{0,0,1,1}, '{0,0,1,1}, '{0,1,1,1}};
    int dc_tab [7][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,0,1}, '{1,1,1,0},
                          '{1,2,0,1}, '{0,1,1,2}, '{0,-1,0,1}};

    piece_fall_engine #(
        .ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPAWN_COL), .YW(YW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spawn(spawn),
        .piece_type(piece_type),
        .tick(tick),
        .hard_drop(hard_drop),
        .board_in(board),
        .piece_mask(piece_mask),
        .block_y(block_y),
        .busy(busy),
        .landed(landed),
        .spawn_fail(spawn_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit fits(int t, int y);
        for (int k = 0; k < 4; k++) begin
            int r = y + dr_tab[t][k];
            int c = SPAWN_COL + dc_tab[t][k];
            if (r >= ROWS) return 1'b0;
            if (board[r*COLS + c]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] model_mask(int t, int y);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            int r = y + dr_tab[t][k];
            int c = SPAWN_COL + dc_tab[t][k];
            if (r < ROWS) m[r*COLS + c] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [N-1:0] exp_mask();
        if (m_mode == M_FALL || m_mode == M_LAND) return model_mask(m_type, m_y);
        return '0;
    endfunction

    function automatic logic [2:0] exp_flags();
        logic [2:0] f;
        f[2] = (m_mode != M_IDLE);
        f[1] = (m_mode == M_LAND);
        f[0] = (m_mode == M_SPAWN) && !fits(m_type, 0);
        return f;
    endfunction

    task automatic model_advance();
        if (!rst) begin
            m_mode = M_IDLE; m_y = 0; m_type = 0; m_hd = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (spawn && piece_type != 3'd7) begin
                    m_type = int'(piece_type); m_y = 0; m_mode = M_SPAWN;
                end
                M_SPAWN: m_mode = fits(m_type, 0) ? M_FALL : M_IDLE;
                M_FALL: begin
                    if (m_hd || hard_drop || tick) begin
                        if (fits(m_type, m_y + 1)) m_y = m_y + 1;
                        else m_mode = M_LAND;
                    end
                    if (hard_drop) m_hd = 1'b1;
                end
                default: begin m_mode = M_IDLE; m_hd = 1'b0; end
            endcase
        end
    endtask

    task automatic drive(input bit sp, input int pt, input bit tk, input bit hd);
        spawn = sp; piece_type = 3'(pt); tick = tk; hard_drop = hd;
        #1;
    endtask

    task automatic tick_clk();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1, 2, 0, 0);
        tick_clk();
        tick_clk();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        n_checks++; if (block_y !== '0) begin n_errors++; $display("FAIL reset_block_y got=%0d exp=0", block_y); end
        n_checks++; if (piece_mask !== '0) begin n_errors++; $display("FAIL reset_mask got=%h exp=0", piece_mask); end
        n_checks++; if ({busy, landed, spawn_fail} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got=%b exp=000", {busy, landed, spawn_fail}); end
        $display("test_reset done");
    endtask

    task automatic test_gravity();
        logic [N-1:0] floor_mask;
        floor_mask = '0;
        for (int r = 16; r < 20; r++) floor_mask[r*COLS + 4] = 1'b1;
        board = '0;
        drive(1, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, piece_mask == '0} !== 2'b11) begin n_errors++; $display("FAIL grav_spawn_state busy=%b mask_zero=%b exp=11", busy, piece_mask == '0); end
        tick_clk();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0);
            n_checks++; if (block_y !== YW'(i)) begin n_errors++; $display("FAIL grav_hold_y got=%0d exp=%0d", block_y, i); end
            n_checks++; if (piece_mask !== model_mask(0, i)) begin n_errors++; $display("FAIL grav_mask y=%0d got=%h exp=%h", i, piece_mask, model_mask(0, i)); end
            tick_clk();
            drive(0, 0, 1, 0);
            n_checks++; if (block_y !== YW'(i)) begin n_errors++; $display("FAIL grav_y_before_tick got=%0d exp=%0d", block_y, i); end
            tick_clk();
        end
        drive(0, 0, 0, 0);
        n_checks++; if (block_y !== YW'(16)) begin n_errors++; $display("FAIL grav_bottom_y got=%0d exp=16", block_y); end
        n_checks++; if (piece_mask !== floor_mask) begin n_errors++; $display("FAIL grav_bottom_mask got=%h exp=%h", piece_mask, floor_mask); end
        n_checks++; if (landed !== 1'b0) begin n_errors++; $display("FAIL grav_early_landed got=%b exp=0", landed); end
        drive(0, 0, 1, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({landed, block_y} !== {1'b1, YW'(16)}) begin n_errors++; $display("FAIL grav_landed landed=%b y=%0d exp landed=1 y=16", landed, block_y); end
        n_checks++; if (piece_mask !== floor_mask) begin n_errors++; $display("FAIL grav_land_mask got=%h exp=%h", piece_mask, floor_mask); end
        tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed} !== 2'b00) begin n_errors++; $display("FAIL grav_idle busy=%b landed=%b exp=00", busy, landed); end
        $display("test_gravity: I piece landed at row 16");
    endtask

    task automatic test_hard_drop();
        board = '0;
        for (int c = 0; c < COLS; c++) board[10*COLS + c] = 1'b1;
        drive(1, 1, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 1);
        n_checks++; if (block_y !== YW'(0)) begin n_errors++; $display("FAIL hd_start_y got=%0d exp=0", block_y); end
        tick_clk();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 0, 0, 0);
            n_checks++; if ({landed, block_y} !== {1'b0, YW'(k)}) begin n_errors++; $display("FAIL hd_step landed=%b y=%0d exp landed=0 y=%0d", landed, block_y, k); end
            tick_clk();
        end
        drive(0, 0, 0, 0);
        n_checks++; if ({landed, block_y} !== {1'b1, YW'(8)}) begin n_errors++; $display("FAIL hd_landed landed=%b y=%0d exp landed=1 y=8", landed, block_y); end
        tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed} !== 2'b00) begin n_errors++; $display("FAIL hd_idle busy=%b landed=%b exp=00", busy, landed); end
        $display("test_hard_drop: O piece locked at row 8 above full row 10");
    endtask

    task automatic test_spawn_fail();
        board = '0;
        board[0*COLS + 4] = 1'b1;
        drive(1, 6, 0, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed, spawn_fail} !== 3'b101) begin n_errors++; $display("FAIL sf_strobe flags=%b exp=101", {busy, landed, spawn_fail}); end
        n_checks++; if (piece_mask !== '0) begin n_errors++; $display("FAIL sf_mask got=%h exp=0", piece_mask); end
        tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed, spawn_fail} !== 3'b000) begin n_errors++; $display("FAIL sf_after flags=%b exp=000", {busy, landed, spawn_fail}); end
        n_checks++; if (piece_mask !== '0) begin n_errors++; $display("FAIL sf_after_mask got=%h exp=0", piece_mask); end
        $display("test_spawn_fail: T piece blocked at spawn");
    endtask

    task automatic test_ignored();
        int guard;
        board = '0;
        drive(1, 7, 0, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, block_y} !== {1'b0, YW'(0)}) begin n_errors++; $display("FAIL ign_type7 busy=%b y=%0d exp busy=0 y=0", busy, block_y); end
        drive(1, 2, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        drive(0, 0, 1, 0); tick_clk();
        drive(0, 0, 1, 0); tick_clk();
        drive(1, 3, 0, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, block_y} !== {1'b1, YW'(2)}) begin n_errors++; $display("FAIL ign_fall_spawn busy=%b y=%0d exp busy=1 y=2", busy, block_y); end
        n_checks++; if (piece_mask !== model_mask(2, 2)) begin n_errors++; $display("FAIL ign_fall_mask got=%h exp=%h", piece_mask, model_mask(2, 2)); end
        drive(0, 0, 0, 1); tick_clk();
        guard = 0;
        drive(0, 0, 0, 0);
        while (!landed && guard < 40) begin
            tick_clk(); drive(0, 0, 0, 0); guard++;
        end
        n_checks++; if ({landed, block_y} !== {1'b1, YW'(17)}) begin n_errors++; $display("FAIL ign_final landed=%b y=%0d exp landed=1 y=17", landed, block_y); end
        tick_clk();
        $display("test_ignored: type 7 and spawn-in-fall both ignored");
    endtask

    task automatic test_same_cycle();
        board = '0;
        drive(1, 4, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 0); tick_clk(); end
        drive(0, 0, 1, 1);
        n_checks++; if (block_y !== YW'(5)) begin n_errors++; $display("FAIL same_start_y got=%0d exp=5", block_y); end
        tick_clk();
        for (int k = 6; k <= 18; k++) begin
            drive(0, 0, 0, 0);
            n_checks++; if ({landed, block_y} !== {1'b0, YW'(k)}) begin n_errors++; $display("FAIL same_step landed=%b y=%0d exp landed=0 y=%0d", landed, block_y, k); end
            tick_clk();
        end
        drive(0, 0, 0, 0);
        n_checks++; if ({landed, block_y} !== {1'b1, YW'(18)}) begin n_errors++; $display("FAIL same_landed landed=%b y=%0d exp landed=1 y=18", landed, block_y); end
        n_checks++; if (piece_mask !== model_mask(4, 18)) begin n_errors++; $display("FAIL same_land_mask got=%h exp=%h", piece_mask, model_mask(4, 18)); end
        tick_clk();
        $display("test_same_cycle: S piece single-step then drop to row 18");
    endtask

    task automatic test_reset_mid_drop();
        board = '0;
        drive(1, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 1); tick_clk();
        for (int k = 1; k < 7; k++) begin drive(0, 0, 0, 0); tick_clk(); end
        drive(0, 0, 0, 0);
        n_checks++; if (block_y !== YW'(7)) begin n_errors++; $display("FAIL rmd_pre_y got=%0d exp=7", block_y); end
        rst = 1'b0; tick_clk(); rst = 1'b1;
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed, block_y} !== {2'b00, YW'(0)}) begin n_errors++; $display("FAIL rmd_after busy=%b landed=%b y=%0d exp 0 0 0", busy, landed, block_y); end
        n_checks++; if (piece_mask !== '0) begin n_errors++; $display("FAIL rmd_mask got=%h exp=0", piece_mask); end
        tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, landed} !== 2'b00) begin n_errors++; $display("FAIL rmd_quiet busy=%b landed=%b exp=00", busy, landed); end
        drive(1, 5, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 0); tick_clk();
        drive(0, 0, 0, 0);
        n_checks++; if ({busy, block_y} !== {1'b1, YW'(0)}) begin n_errors++; $display("FAIL rmd_restart busy=%b y=%0d exp busy=1 y=0 (drop latch must be clear)", busy, block_y); end
        n_checks++; if (piece_mask !== model_mask(5, 0)) begin n_errors++; $display("FAIL rmd_restart_mask got=%h exp=%h", piece_mask, model_mask(5, 0)); end
        drive(0, 0, 0, 1); tick_clk();
        for (int g = 0; g < 30 && m_mode != M_IDLE; g++) begin drive(0, 0, 0, 0); tick_clk(); end
        $display("test_reset_mid_drop: reset aborted drop, restart ok");
    endtask

    task automatic test_random();
        int pieces;
        int dens;
        pieces = 0;
        board = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) < 3) begin
                dens = $urandom_range(0, 15);
                board = '0;
                for (int b = 0; b < N; b++)
                    if ($urandom_range(0, 99) < dens) board[b] = 1'b1;
                if ($urandom_range(0, 9) < 7) board[4*COLS-1:0] = '0;
            end else if ($urandom_range(0, 99) < 5) begin
                board[$urandom_range(0, N-1)] ^= 1'b1;
            end
            rst = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
            n_checks++; if (block_y !== YW'(m_y)) begin n_errors++; $display("FAIL rand_y cyc=%0d got=%0d exp=%0d", cyc, block_y, m_y); end
            n_checks++; if (piece_mask !== exp_mask()) begin n_errors++; $display("FAIL rand_mask cyc=%0d got=%h exp=%h", cyc, piece_mask, exp_mask()); end
            n_checks++; if ({busy, landed, spawn_fail} !== exp_flags()) begin n_errors++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {busy, landed, spawn_fail}, exp_flags()); end
            if (exp_flags() & 3'b011) begin
                pieces++;
                $display("rand piece %0d type=%0d row=%0d %s", pieces, m_type, m_y,
                         (m_mode == M_LAND) ? "locked" : "blocked at spawn");
            end
            tick_clk();
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_hard_drop();
        test_spawn_fail();
        test_ignored();
        test_same_cycle();
        test_reset_mid_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/piece_fall_engine.md
Name: piece_fall_engine

Overview:
- Parametrised successor to the single-column falling-block stepper. Owns the active tetromino from spawn to landing on a configurable ROWS x COLS playfield.
- Each gravity tick advances the piece one row. Collision is checked against the locked-cell board supplied by the board store, not only against the floor.
- Supports hard drop, which descends one row per clock until collision.
- Produces the live piece mask plus a one-cycle landed strobe, which the board store uses to merge the piece.

Parameters:
- ROWS, 20, playfield height in rows; row 0 is the top.
- COLS, 10, playfield width in columns.
- SPAWN_COL, 4, column of shape offset 0; constraint 1 <= SPAWN_COL <= COLS-3.
- YW, 5, width of the row index; constraint 2^YW > ROWS+3.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; low = reset).
- spawn  in  1  request a new piece; honoured only in IDLE.
- piece_type  in  3  0=I, 1=O, 2=L, 3=J, 4=S, 5=Z, 6=T, 7=invalid; sampled with spawn.
- tick  in  1  gravity step pulse.
- hard_drop  in  1  request a hard drop; honoured only in FALL.
- board_in  in  ROWS*COLS  locked cells, [row][col]; 1 = occupied.
- piece_mask  out  ROWS*COLS  cells of the active piece at its current row.
- block_y  out  YW  current top row of the piece.
- busy  out  1  high when state != IDLE.
- landed  out  1  one-cycle strobe when the piece locks.
- spawn_fail  out  1  one-cycle strobe when spawn is blocked (game over).

Behaviour:

Shape offsets are (row, col) relative to (block_y, SPAWN_COL); S denotes SPAWN_COL.
- I: (0,0) (1,0) (2,0) (3,0)
- O: (0,0) (0,1) (1,0) (1,1)
- L: (0,0) (1,0) (2,0) (2,1)
- J: (0,1) (1,1) (2,1) (2,0)
- S: (0,1) (0,2) (1,0) (1,1)
- Z: (0,0) (0,1) (1,1) (1,2)
- T: (0,0) (1,-1) (1,0) (1,1)

Fit rule: fits(t,y) is true iff every cell's row y+dr < ROWS and board_in at that cell is 0. Row arithmetic is done in YW+1 bits, so there is no wrap.

Reset (rst low at posedge):
- State goes to IDLE; block_y=0; type register=0; hard-drop latch=0; landed=0; spawn_fail=0.
- piece_mask is 0.
- Reset overrides any operation in flight, including during a hard drop.

IDLE:
- spawn=1 with piece_type != 7: latch the type, set block_y=0, go to SPAWN.
- spawn with piece_type=7 is ignored; the block stays in IDLE with no strobe.
- piece_mask=0.

SPAWN (1 cycle):
- If fits(type,0): go to FALL.
- Otherwise: spawn_fail=1 for exactly this cycle, then go to IDLE.

FALL:
- piece_mask shows the latched type at block_y. It is combinational from registered state.
- hard_drop=1 sets the hard-drop latch.
- When the latch is set, or on the cycle hard_drop is first asserted, the block steps every cycle and ignores tick.
- Otherwise the block steps only on cycles with tick=1.
- Step action:
  - If fits(type, block_y+1): block_y <= block_y+1.
  - Otherwise: go to LAND and leave block_y unchanged.
- tick and hard_drop in the same cycle count as one step, not two.
- spawn is ignored in this state.

LAND (1 cycle):
- landed=1.
- piece_mask still shows the final position so the board store can merge it on this edge.
- Then go to IDLE and clear the hard-drop latch.

General rules:
- board_in may change at any cycle. Collision always uses the current value.
- A piece that already overlaps board_in in FALL is not re-checked at its own row; only the destination row is tested.
- Latency:
  - spawn to first visible piece_mask: 2 cycles.
  - Blocking tick to landed: 1 cycle.
- busy is high in SPAWN, FALL and LAND.

Test Plan:
- Empty board, spawn type 0 (I), 16 ticks: block_y goes 0..16, and the mask rows 16..19 at col 4 are set. The 17th tick produces landed=1 one cycle later, with block_y=16 held.
- Board row 10 full, spawn type 1 (O), hard_drop pulse: block_y increments every cycle with no ticks until it reaches 8. Then landed=1 and busy=0 on the next cycle.
- board_in cell (0,4)=1, spawn type 6 (T): spawn_fail=1 for one cycle, landed stays 0, state returns to IDLE and piece_mask stays 0.
- Spawn type 7, and separately spawn asserted during FALL: both are ignored; block_y, state and busy are unchanged.
- Spawn type 4 (S); at block_y=5, tick and hard_drop in the same cycle: block_y=6, not 7. After that, descent continues one row per cycle to the floor at 18.
- Mid hard drop at block_y=7, rst held low for one edge: the next cycle shows IDLE, block_y=0, piece_mask=0 and no landed strobe. A spawn afterwards restarts normally.
